// File: rtl/matrix_pkg.sv
// Shared definitions for the 5x5 matrix ALU datapath.
//   ELEM_W  : bits per element (two's complement, passed through bit-exact)
//   N_ELEM  : elements per matrix, row-major, element 0 = row 0 col 0
//   FLAT_W  : width of a flattened matrix bus
//   IDX_W   : width of the element index counter
//   ld_state_t : operand loader state encoding
package matrix_pkg;
  localparam int unsigned ELEM_W = 8;
  localparam int unsigned N_ELEM = 25;
  localparam int unsigned FLAT_W = ELEM_W * N_ELEM;
  localparam int unsigned IDX_W  = $clog2(N_ELEM);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    READY  = 2'd3
  } ld_state_t;
endpackage

// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
// Collects 25 bytes of matrix A followed by 25 bytes of matrix B from a
// valid/ready byte stream and presents them as flat buses to the ALU.
// Operands stay stable with operands_valid high until op_ack.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : begin a new load (honoured in IDLE only)
//   in_data/in_valid/in_ready : byte stream; in_ready decoded from state only
//   A_flat, B_flat  : element i at [i*ELEM_W +: ELEM_W]
//   operands_valid  : both matrices complete (READY state)
//   op_ack          : consumer has taken the operands (honoured in READY only)
//   busy            : high in LOAD_A, LOAD_B and READY
module matrix_operand_loader
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ELEM_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FLAT_W-1:0] A_flat,
  output logic [FLAT_W-1:0] B_flat,
  output logic              operands_valid,
  input  logic              op_ack,
  output logic              busy
);

  ld_state_t        state, state_next;
  logic [IDX_W-1:0] elem_idx;
  logic             xfer;
  logic             last_elem;

  assign xfer      = in_valid && in_ready;
  assign last_elem = (elem_idx == IDX_W'(N_ELEM - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    in_ready       = 1'b0;
    operands_valid = 1'b0;
    busy           = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = LOAD_A;
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (xfer && last_elem) state_next = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (xfer && last_elem) state_next = READY;
      end
      READY: begin
        operands_valid = 1'b1;
        if (op_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Index wraps explicitly at N_ELEM-1 so the A->B and B->READY hand-offs
  // both restart at element 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      elem_idx <= '0;
      A_flat   <= '0;
      B_flat   <= '0;
    end else begin
      if (state == IDLE && start) begin
        elem_idx <= '0;
      end else if (xfer) begin
        if (state == LOAD_A) A_flat[elem_idx*ELEM_W +: ELEM_W] <= in_data;
        else                 B_flat[elem_idx*ELEM_W +: ELEM_W] <= in_data;
        elem_idx <= last_elem ? '0 : elem_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_matrix_operand_loader.sv
module tb_matrix_operand_loader;
  logic         clk = 1'b0;
  logic         rst, start, in_valid, op_ack;
  logic [7:0]   in_data;
  logic         in_ready, operands_valid, busy;
  logic [199:0] A_flat, B_flat;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [199:0] exp_a, exp_b;
  logic [199:0] snap_a, snap_b;

  matrix_operand_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .A_flat(A_flat),
    .B_flat(B_flat), .operands_valid(operands_valid), .op_ack(op_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int cyc;
    for (int i = 0; i < 25; i++) begin
      exp_a[i*8 +: 8] = 8'(i);
      exp_b[i*8 +: 8] = 8'(8'h80 + i);
    end

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; op_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ov", operands_valid, 0);
    chk("rst_a", A_flat, 0);
    chk("rst_b", B_flat, 0);

    // Back-to-back load
    start = 1'b1; step(); start = 1'b0;
    chk("t1_in_ready_after_start", in_ready, 1);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 50; i++) begin
      in_valid = 1'b1;
      in_data  = (i < 25) ? 8'(i) : 8'(8'h80 + i - 25);
      step();
      if (i == 24) chk("t1_in_ready_load_b", in_ready, 1);
      if (i == 48) chk("t1_ov_before_last", operands_valid, 0);
    end
    in_valid = 1'b0;
    chk("t1_ov_after_last", operands_valid, 1);
    chk("t1_in_ready_ready", in_ready, 0);
    chk("t1_a_lo", A_flat[7:0], 8'h00);
    chk("t1_a_hi", A_flat[199:192], 8'h18);
    chk("t1_b_lo", B_flat[7:0], 8'h80);
    chk("t1_b_hi", B_flat[199:192], 8'h98);
    chk("t1_a_full", A_flat, exp_a);
    chk("t1_b_full", B_flat, exp_b);

    // start in READY ignored; hold 20 cycles without op_ack
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 8'h5A;
      step();
      chk("t4_ov_hold", operands_valid, 1);
    end
    in_valid = 1'b0;
    chk("t4_a_stable", A_flat, exp_a);
    chk("t4_b_stable", B_flat, exp_b);

    // op_ack with start in READY
    op_ack = 1'b1; start = 1'b1; step(); op_ack = 1'b0; start = 1'b0;
    chk("t5_ov_drop", operands_valid, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_busy", busy, 0);
    step();
    chk("t5_in_ready_later", in_ready, 0);

    // in_valid in IDLE and op_ack in LOAD_A ignored
    in_valid = 1'b1; in_data = 8'h7F;
    step(); step();
    chk("t6_a_unchanged", A_flat, exp_a);
    start = 1'b1; step(); start = 1'b0;  // in_valid still high during start
    in_valid = 1'b0;
    chk("t6_a_after_start", A_flat, exp_a);
    op_ack = 1'b1; step(); op_ack = 1'b0;
    chk("t6_still_load", in_ready, 1);
    chk("t6_ov", operands_valid, 0);
    in_valid = 1'b1; in_data = 8'h11; step();
    chk("t6_elem0", A_flat[15:0], 16'h0111);
    for (int i = 1; i < 10; i++) begin
      in_data = 8'h11; step();
    end
    in_valid = 1'b0;

    // Reset mid-load
    rst = 1'b1; step(); rst = 1'b0;
    chk("t3_in_ready", in_ready, 0);
    chk("t3_busy", busy, 0);
    chk("t3_a_zero", A_flat, 0);
    chk("t3_ov", operands_valid, 0);

    // Stalled load, start pulsed during LOAD_B
    start = 1'b1; step(); start = 1'b0;
    sent = 0;
    cyc  = 0;
    while (sent < 50 && cyc < 300) begin
      start = (sent == 30) ? 1'b1 : 1'b0;
      if (cyc % 3 == 0) begin
        in_valid = 1'b1;
        in_data  = (sent < 25) ? 8'(sent) : 8'(8'h80 + sent - 25);
        sent++;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
      end
      step();
      cyc++;
      chk("t2_ov_track", operands_valid, (sent == 50) ? 1 : 0);
    end
    in_valid = 1'b0; start = 1'b0;
    chk("t2_done_in_budget", (sent == 50) ? 1 : 0, 1);
    chk("t2_a_full", A_flat, exp_a);
    chk("t2_b_full", B_flat, exp_b);
    start = 1'b1; step(); start = 1'b0;
    chk("t2_start_ready_ignored", operands_valid, 1);
    op_ack = 1'b1; step(); op_ack = 1'b0;
    chk("t2_ack_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
